// File: rtl/multicycle_control_sequencer_pkg.sv
// Shared types for the multicycle control sequencer: control-line enums, decode bundle,
// halt causes, FSM state encoding and the halt-priority resolver.
package multicycle_control_sequencer_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        MM_NOP, MM_LOAD, MM_STORE_PRELOAD, MM_STORE
    } MemoryMode_t;

    typedef enum logic [4:0] {
        RD_NONE        = 5'b00000,
        RD_ALU         = 5'b00001,
        RD_IMMEDIATE   = 5'b00010,
        RD_PC_PLUS_4   = 5'b00100,
        RD_PC_PLUS_IMM = 5'b01000,
        RD_MEMORY      = 5'b10000
    } RDSourceSelectLines_t;

    typedef enum logic {
        IAS_CURRENT_PC, IAS_NEXT_PC
    } InstructionAddressSource_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } ImmediateFormerMode_t;

    typedef enum logic [1:0] {
        BR_NONE, BR_COND, BR_JAL, BR_JALR
    } BranchALUMode_t;

    typedef enum logic [3:0] {
        HC_NONE, HC_BAD_OPCODE, HC_PC_MISALIGNED, HC_BRANCH_FUNCT3, HC_MEM_FUNCT3,
        HC_MEM_MISALIGNED, HC_ECALL, HC_EBREAK, HC_MEM_TIMEOUT, HC_BAD_STATE
    } HaltCause_t;

    typedef enum logic [4:0] {
        ST_INITIAL_FETCH = 5'b00001,
        ST_FETCH_EXECUTE = 5'b00010,
        ST_MEM_PRELOAD   = 5'b00100,
        ST_MEM_ACCESS    = 5'b01000,
        ST_HALT          = 5'b10000
    } ControlState_t;

    // CLS_BAD is the zero encoding so a cleared decode bundle means "illegal".
    typedef enum logic [2:0] {
        CLS_BAD, CLS_SIMPLE, CLS_LOAD, CLS_STORE, CLS_SYSTEM
    } InstrClass_t;

    typedef struct packed {
        InstrClass_t          cls;
        logic                 rdWriteEnable;
        logic                 opImm;
        RDSourceSelectLines_t rdSrc;
        ImmediateFormerMode_t immMode;
        BranchALUMode_t       branchMode;
        logic                 isSubwordStore;
    } decode_t;

    function automatic HaltCause_t halt_priority(
        input logic bad_op, input logic pc_mis, input logic br_f3, input logic mem_f3,
        input logic mem_mis, input logic sys, input logic ebreak, input logic tmo
    );
        HaltCause_t hc;
        hc = HC_NONE;
        if (bad_op)       hc = HC_BAD_OPCODE;
        else if (pc_mis)  hc = HC_PC_MISALIGNED;
        else if (br_f3)   hc = HC_BRANCH_FUNCT3;
        else if (mem_f3)  hc = HC_MEM_FUNCT3;
        else if (mem_mis) hc = HC_MEM_MISALIGNED;
        else if (sys)     hc = ebreak ? HC_EBREAK : HC_ECALL;
        else if (tmo)     hc = HC_MEM_TIMEOUT;
        return hc;
    endfunction

endpackage

// File: rtl/multicycle_control_sequencer_if.sv
// Bundle between the sequencer (master) and the instruction register / datapath (slave).
interface multicycle_control_sequencer_if #(
    parameter int RETIRE_WIDTH = 32
);
    import multicycle_control_sequencer_pkg::*;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      systemImm0;
    logic                      memReady;
    logic                      resume;
    logic                      branchALUBadFunct3;
    logic                      programCounterMisaligned;
    logic                      memoryUnalignedAccess;
    logic                      memoryBadFunct3;

    logic                      memRequest;
    logic                      rdWriteEnable;
    logic                      programCounterWriteEnable;
    logic                      opImm;
    MemoryMode_t               memoryMode;
    RDSourceSelectLines_t      rdSourceSelectLines;
    InstructionAddressSource_t instructionAddressSource;
    ImmediateFormerMode_t      immediateFormerMode;
    BranchALUMode_t            branchALUMode;
    logic                      halted;
    HaltCause_t                haltCause;
    logic [RETIRE_WIDTH-1:0]   retiredCount;

    modport master (
        input  opcode, funct3, systemImm0, memReady, resume,
               branchALUBadFunct3, programCounterMisaligned, memoryUnalignedAccess, memoryBadFunct3,
        output memRequest, rdWriteEnable, programCounterWriteEnable, opImm, memoryMode,
               rdSourceSelectLines, instructionAddressSource, immediateFormerMode, branchALUMode,
               halted, haltCause, retiredCount
    );

    modport slave (
        output opcode, funct3, systemImm0, memReady, resume,
               branchALUBadFunct3, programCounterMisaligned, memoryUnalignedAccess, memoryBadFunct3,
        input  memRequest, rdWriteEnable, programCounterWriteEnable, opImm, memoryMode,
               rdSourceSelectLines, instructionAddressSource, immediateFormerMode, branchALUMode,
               halted, haltCause, retiredCount
    );

endinterface

// File: rtl/multicycle_control_sequencer_instruction_class_decoder.sv
// Combinational opcode/funct3 decode into instruction class and single-cycle control lines.
module multicycle_control_sequencer_instruction_class_decoder
    import multicycle_control_sequencer_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output decode_t    dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OPC_LUI: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1;
                dec_o.rdSrc = RD_IMMEDIATE; dec_o.immMode = IMM_U;
            end
            OPC_AUIPC: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1;
                dec_o.rdSrc = RD_PC_PLUS_IMM; dec_o.immMode = IMM_U;
            end
            OPC_JAL: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1;
                dec_o.rdSrc = RD_PC_PLUS_4; dec_o.immMode = IMM_J; dec_o.branchMode = BR_JAL;
            end
            OPC_JALR: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1;
                dec_o.rdSrc = RD_PC_PLUS_4; dec_o.immMode = IMM_I; dec_o.branchMode = BR_JALR;
            end
            OPC_BRANCH: begin
                dec_o.cls = CLS_SIMPLE; dec_o.immMode = IMM_B; dec_o.branchMode = BR_COND;
            end
            OPC_OPIMM: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1;
                dec_o.rdSrc = RD_ALU; dec_o.immMode = IMM_I; dec_o.opImm = 1'b1;
            end
            OPC_OP: begin
                dec_o.cls = CLS_SIMPLE; dec_o.rdWriteEnable = 1'b1; dec_o.rdSrc = RD_ALU;
            end
            OPC_FENCE: dec_o.cls = CLS_SIMPLE;
            OPC_LOAD: begin
                dec_o.cls = CLS_LOAD; dec_o.immMode = IMM_I;
            end
            OPC_STORE: begin
                dec_o.cls = CLS_STORE; dec_o.immMode = IMM_S;
                dec_o.isSubwordStore = (funct3_i[1:0] != 2'b10);
            end
            // Only ecall/ebreak are supported; CSR forms are treated as illegal.
            OPC_SYSTEM: dec_o.cls = (funct3_i == 3'b000) ? CLS_SYSTEM : CLS_BAD;
            default: dec_o.cls = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_sequencer.sv
// Multicycle control FSM: fetch/execute, memory handshake with optional RMW preload and timeout,
// latched halt cause with ebreak debug resume, and a retired-instruction counter.
module multicycle_control_sequencer
    import multicycle_control_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit RMW_STORES     = 1'b1,
    parameter int RETIRE_WIDTH   = 32
) (
    input logic                          clock,
    input logic                          reset,
    multicycle_control_sequencer_if.master bus
);

    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    decode_t                   dec;
    ControlState_t             state_q, state_d;
    HaltCause_t                cause_q, cause_d, cause_now;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [RETIRE_WIDTH-1:0]   retired_q, retired_d;
    logic                      retire, in_mem, tmo_hit, preload, is_mem;
    MemoryMode_t               access_mode;

    logic                      mem_req, rd_we, pc_we, op_imm;
    MemoryMode_t               mem_mode;
    RDSourceSelectLines_t      rd_src;
    InstructionAddressSource_t ias;
    ImmediateFormerMode_t      imm_mode;
    BranchALUMode_t            br_mode;

    multicycle_control_sequencer_instruction_class_decoder u_dec (
        .opcode_i (bus.opcode),
        .funct3_i (bus.funct3),
        .dec_o    (dec)
    );

    assign in_mem      = (state_q == ST_MEM_PRELOAD) || (state_q == ST_MEM_ACCESS);
    assign is_mem      = (dec.cls == CLS_LOAD) || (dec.cls == CLS_STORE);
    assign preload     = (dec.cls == CLS_STORE) && dec.isSubwordStore && RMW_STORES;
    assign access_mode = (dec.cls == CLS_LOAD) ? MM_LOAD : MM_STORE;
    // memReady in the expiry cycle beats the timeout.
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && in_mem && !bus.memReady && (tmo_q == TW'(TLIM));

    assign cause_now = halt_priority(dec.cls == CLS_BAD, bus.programCounterMisaligned,
                                     bus.branchALUBadFunct3, bus.memoryBadFunct3,
                                     bus.memoryUnalignedAccess, dec.cls == CLS_SYSTEM,
                                     bus.systemImm0, tmo_hit);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_mode = MM_NOP;
        rd_we    = 1'b0;
        pc_we    = 1'b0;
        op_imm   = 1'b0;
        rd_src   = RD_NONE;
        ias      = IAS_CURRENT_PC;
        imm_mode = IMM_NONE;
        br_mode  = BR_NONE;
        case (state_q)
            ST_INITIAL_FETCH: state_d = ST_FETCH_EXECUTE;
            ST_FETCH_EXECUTE: begin
                imm_mode = dec.immMode;
                br_mode  = dec.branchMode;
                op_imm   = dec.opImm;
                if (is_mem) begin
                    mem_req  = 1'b1;
                    mem_mode = preload ? MM_STORE_PRELOAD : access_mode;
                    state_d  = preload ? ST_MEM_PRELOAD : ST_MEM_ACCESS;
                end else begin
                    rd_we  = dec.rdWriteEnable;
                    rd_src = dec.rdSrc;
                    pc_we  = 1'b1;
                    ias    = IAS_NEXT_PC;
                    retire = 1'b1;
                end
            end
            ST_MEM_PRELOAD: begin
                imm_mode = dec.immMode;
                mem_req  = 1'b1;
                mem_mode = MM_STORE_PRELOAD;
                if (bus.memReady) state_d = ST_MEM_ACCESS;
            end
            ST_MEM_ACCESS: begin
                imm_mode = dec.immMode;
                mem_req  = 1'b1;
                mem_mode = access_mode;
                if (bus.memReady) begin
                    if (dec.cls == CLS_LOAD) begin
                        rd_we  = 1'b1;
                        rd_src = RD_MEMORY;
                    end
                    pc_we   = 1'b1;
                    ias     = IAS_NEXT_PC;
                    retire  = 1'b1;
                    state_d = ST_FETCH_EXECUTE;
                end
            end
            ST_HALT: begin
                if (cause_q == HC_EBREAK && bus.resume) begin
                    pc_we   = 1'b1;
                    ias     = IAS_NEXT_PC;
                    retire  = 1'b1;
                    cause_d = HC_NONE;
                    state_d = ST_FETCH_EXECUTE;
                end
            end
            default: begin
                state_d = ST_HALT;
                cause_d = HC_BAD_STATE;
            end
        endcase
        // A halting cycle never writes or retires.
        if ((state_q == ST_FETCH_EXECUTE || in_mem) && cause_now != HC_NONE) begin
            rd_we   = 1'b0;
            pc_we   = 1'b0;
            retire  = 1'b0;
            state_d = ST_HALT;
            cause_d = cause_now;
        end
    end

    assign tmo_d     = (in_mem && state_d == state_q) ? tmo_q + TW'(1) : '0;
    assign retired_d = retire ? retired_q + RETIRE_WIDTH'(1) : retired_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INITIAL_FETCH;
            cause_q   <= HC_NONE;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
        end
    end

    assign bus.memRequest                = mem_req;
    assign bus.rdWriteEnable             = rd_we;
    assign bus.programCounterWriteEnable = pc_we;
    assign bus.opImm                     = op_imm;
    assign bus.memoryMode                = mem_mode;
    assign bus.rdSourceSelectLines       = rd_src;
    assign bus.instructionAddressSource  = ias;
    assign bus.immediateFormerMode       = imm_mode;
    assign bus.branchALUMode             = br_mode;
    assign bus.halted                    = (state_q == ST_HALT);
    assign bus.haltCause                 = cause_q;
    assign bus.retiredCount              = retired_q;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Directed bench: two sequencers (RMW on / RMW off, timeout 4) driven with identical stimulus.
module tb_multicycle_control_sequencer;
    import multicycle_control_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    multicycle_control_sequencer_if #(.RETIRE_WIDTH(32)) ia ();
    multicycle_control_sequencer_if #(.RETIRE_WIDTH(32)) ib ();

    multicycle_control_sequencer #(.TIMEOUT_CYCLES(4), .RMW_STORES(1'b1), .RETIRE_WIDTH(32)) dut_a (
        .clock (clock), .reset (reset), .bus (ia));
    multicycle_control_sequencer #(.TIMEOUT_CYCLES(4), .RMW_STORES(1'b0), .RETIRE_WIDTH(32)) dut_b (
        .clock (clock), .reset (reset), .bus (ib));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // fl = {branchBadFunct3, pcMisaligned, memBadFunct3, memUnaligned}
    task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic imm0,
                       input logic rdy, input logic res, input logic [3:0] fl);
        ia.opcode = op;    ib.opcode = op;
        ia.funct3 = f3;    ib.funct3 = f3;
        ia.systemImm0 = imm0; ib.systemImm0 = imm0;
        ia.memReady = rdy; ib.memReady = rdy;
        ia.resume = res;   ib.resume = res;
        ia.branchALUBadFunct3 = fl[3];       ib.branchALUBadFunct3 = fl[3];
        ia.programCounterMisaligned = fl[2]; ib.programCounterMisaligned = fl[2];
        ia.memoryBadFunct3 = fl[1];          ib.memoryBadFunct3 = fl[1];
        ia.memoryUnalignedAccess = fl[0];    ib.memoryUnalignedAccess = fl[0];
        #1;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        drv(OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        #2;
        chk("rst_halted", 32'(ia.halted), 32'd0);
        chk("rst_memreq", 32'(ia.memRequest), 32'd0);
        chk("rst_mode", 32'(ia.memoryMode), 32'(MM_NOP));
        chk("rst_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        chk("rst_cause", 32'(ia.haltCause), 32'(HC_NONE));
        chk("rst_retired", ia.retiredCount, 32'd0);
        #19 reset = 1'b1;
        #1;
        chk("if_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        chk("if_ias", 32'(ia.instructionAddressSource), 32'(IAS_CURRENT_PC));
        cyc();

        // addi, add, lui: one cycle each
        drv(OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        chk("addi_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        chk("addi_rdwe", 32'(ia.rdWriteEnable), 32'd1);
        chk("addi_opimm", 32'(ia.opImm), 32'd1);
        chk("addi_src", 32'(ia.rdSourceSelectLines), 32'(RD_ALU));
        chk("addi_ias", 32'(ia.instructionAddressSource), 32'(IAS_NEXT_PC));
        cyc();
        drv(OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        chk("add_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        chk("add_opimm", 32'(ia.opImm), 32'd0);
        cyc();
        drv(OPC_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        chk("lui_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        chk("lui_src", 32'(ia.rdSourceSelectLines), 32'(RD_IMMEDIATE));
        chk("lui_imm", 32'(ia.immediateFormerMode), 32'(IMM_U));
        cyc();
        chk("seq_retired", ia.retiredCount, 32'd3);

        // lw, ready after 2 MEM_ACCESS cycles
        drv(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 4'b0);
        chk("lw_fe_memreq", 32'(ia.memRequest), 32'd1);
        chk("lw_fe_mode", 32'(ia.memoryMode), 32'(MM_LOAD));
        chk("lw_fe_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("lw_wait_rdwe", 32'(ia.rdWriteEnable), 32'd0);
            chk("lw_wait_src", 32'(ia.rdSourceSelectLines), 32'(RD_NONE));
            chk("lw_wait_memreq", 32'(ia.memRequest), 32'd1);
        end
        cyc();
        drv(OPC_LOAD, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0);
        chk("lw_rdy_rdwe", 32'(ia.rdWriteEnable), 32'd1);
        chk("lw_rdy_src", 32'(ia.rdSourceSelectLines), 32'(RD_MEMORY));
        chk("lw_rdy_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        cyc();
        chk("lw_retired", ia.retiredCount, 32'd4);

        // sb: preload path on dut_a, single-phase on dut_b
        drv(OPC_STORE, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0);
        chk("sb_a_fe_mode", 32'(ia.memoryMode), 32'(MM_STORE_PRELOAD));
        chk("sb_b_fe_mode", 32'(ib.memoryMode), 32'(MM_STORE));
        cyc();
        chk("sb_a_pre_mode", 32'(ia.memoryMode), 32'(MM_STORE_PRELOAD));
        chk("sb_b_acc_mode", 32'(ib.memoryMode), 32'(MM_STORE));
        chk("sb_b_wait_pcwe", 32'(ib.programCounterWriteEnable), 32'd0);
        cyc();
        drv(OPC_STORE, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0);
        chk("sb_a_pre_rdy_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        chk("sb_a_pre_rdy_mode", 32'(ia.memoryMode), 32'(MM_STORE_PRELOAD));
        chk("sb_b_rdy_pcwe", 32'(ib.programCounterWriteEnable), 32'd1);
        cyc();
        chk("sb_b_retired", ib.retiredCount, 32'd5);
        chk("sb_a_acc_mode", 32'(ia.memoryMode), 32'(MM_STORE));
        chk("sb_a_acc_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        chk("sb_a_acc_rdwe", 32'(ia.rdWriteEnable), 32'd0);
        cyc();
        chk("sb_a_retired", ia.retiredCount, 32'd5);

        // lw with memReady never asserted -> timeout after 4 MEM_ACCESS cycles
        drv(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 4'b0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_not_halted", 32'(ia.halted), 32'd0);
            cyc();
        end
        chk("tmo_halted", 32'(ia.halted), 32'd1);
        chk("tmo_cause", 32'(ia.haltCause), 32'(HC_MEM_TIMEOUT));
        chk("tmo_memreq", 32'(ia.memRequest), 32'd0);
        drv(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, 4'b0);
        chk("tmo_resume_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        cyc();
        chk("tmo_resume_halted", 32'(ia.halted), 32'd1);
        chk("tmo_retired", ia.retiredCount, 32'd5);

        // ebreak then resume
        drv(OPC_SYSTEM, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0);
        do_reset();
        chk("post_rst_retired", ia.retiredCount, 32'd0);
        chk("ebk_fe_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        cyc();
        chk("ebk_halted", 32'(ia.halted), 32'd1);
        chk("ebk_cause", 32'(ia.haltCause), 32'(HC_EBREAK));
        chk("ebk_retired", ia.retiredCount, 32'd0);
        drv(OPC_SYSTEM, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0);
        chk("ebk_res_pcwe", 32'(ia.programCounterWriteEnable), 32'd1);
        chk("ebk_res_ias", 32'(ia.instructionAddressSource), 32'(IAS_NEXT_PC));
        cyc();
        chk("ebk_res_halted", 32'(ia.halted), 32'd0);
        chk("ebk_res_cause", 32'(ia.haltCause), 32'(HC_NONE));
        chk("ebk_res_retired", ia.retiredCount, 32'd1);

        // reset asserted mid-MEM_ACCESS
        drv(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 4'b0);
        cyc();
        chk("mid_memreq", 32'(ia.memRequest), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_memreq", 32'(ia.memRequest), 32'd0);
        chk("mid_rst_mode", 32'(ia.memoryMode), 32'(MM_NOP));
        chk("mid_rst_retired", ia.retiredCount, 32'd0);
        chk("mid_rst_halted", 32'(ia.halted), 32'd0);
        #1 reset = 1'b1;
        cyc();

        // ecall + resume stays halted
        drv(OPC_SYSTEM, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        cyc();
        chk("ecall_cause", 32'(ia.haltCause), 32'(HC_ECALL));
        drv(OPC_SYSTEM, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0);
        chk("ecall_res_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        cyc();
        chk("ecall_res_halted", 32'(ia.halted), 32'd1);

        // bad opcode beats pc misaligned
        drv(7'b0000001, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
        do_reset();
        chk("badop_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        cyc();
        chk("badop_cause", 32'(ia.haltCause), 32'(HC_BAD_OPCODE));

        // branch funct3 beats mem misaligned on a plain addi
        drv(OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 4'b1001);
        do_reset();
        chk("prio_pcwe", 32'(ia.programCounterWriteEnable), 32'd0);
        cyc();
        chk("prio_cause", 32'(ia.haltCause), 32'(HC_BRANCH_FUNCT3));
        chk("prio_retired", ia.retiredCount, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
